// File: rtl/free_slot_alloc_pkg.sv
// Shared types and defaults for slot allocators (RS entries, physical registers, ROB).
package free_slot_alloc_pkg;

  localparam int DEFAULT_WIDTH = 5;
  localparam int DEFAULT_DEPTH = 1 << DEFAULT_WIDTH;

  typedef logic [DEFAULT_WIDTH-1:0] slot_idx_t;
  typedef logic [DEFAULT_WIDTH:0]   slot_cnt_t;

endpackage

// File: rtl/free_slot_alloc_if.sv
// Allocation/release bus between rename-dispatch, commit-issue and the free-slot allocator.
interface free_slot_alloc_if
  import free_slot_alloc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             flush_i;
  logic             alloc_req_i;
  logic             alloc_valid_o;
  logic [WIDTH-1:0] alloc_idx_o;
  logic             free_valid_i;
  logic [WIDTH-1:0] free_idx_i;
  logic [WIDTH:0]   free_count_o;
  logic             empty_o;
  logic             double_free_o;

  modport master (
    output flush_i, alloc_req_i, free_valid_i, free_idx_i,
    input  alloc_valid_o, alloc_idx_o, free_count_o, empty_o, double_free_o
  );

  modport slave (
    input  flush_i, alloc_req_i, free_valid_i, free_idx_i,
    output alloc_valid_o, alloc_idx_o, free_count_o, empty_o, double_free_o
  );

endinterface

// File: rtl/free_slot_alloc_lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder; also usable by issue-select logic.
module lsb_prio_enc
  import free_slot_alloc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 1 << WIDTH
) (
  input  logic [DEPTH-1:0] req_vec,
  output logic [WIDTH-1:0] idx,
  output logic             valid
);

  // Scanning from the top down lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_vec[i]) idx = WIDTH'(i);
    end
  end

  assign valid = |req_vec;

endmodule

// File: rtl/free_slot_alloc.sv
// Free-slot allocator: grants the lowest free index each cycle, takes released indices back.
module free_slot_alloc
  import free_slot_alloc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 1 << WIDTH
) (
  input logic              clk_i,
  input logic              rst_ni,
  free_slot_alloc_if.slave bus
);

  localparam logic [WIDTH:0] DEPTH_CNT = (WIDTH + 1)'(DEPTH);
  localparam logic [WIDTH:0] CNT_ONE   = (WIDTH + 1)'(1);

  logic [DEPTH-1:0] free_map, free_map_next;
  logic [DEPTH-1:0] free_onehot, alloc_onehot, free_new;
  logic [WIDTH:0]   free_cnt, free_cnt_next;
  logic             dbl_err, dbl_err_next;
  logic [WIDTH-1:0] low_idx;
  logic             any_free;
  logic             alloc_fire, free_eff, free_dbl;

  lsb_prio_enc #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_enc (
    .req_vec (free_map),
    .idx     (low_idx),
    .valid   (any_free)
  );

  always_comb begin
    free_onehot  = '0;
    alloc_onehot = '0;
    alloc_fire   = bus.alloc_req_i && any_free;
    for (int i = 0; i < DEPTH; i++) begin
      free_onehot[i]  = bus.free_valid_i && (bus.free_idx_i == WIDTH'(i));
      alloc_onehot[i] = alloc_fire && (low_idx == WIDTH'(i));
    end
  end

  // Only a release of a busy slot has effect; out-of-range or already-free is a double free.
  assign free_new = free_onehot & ~free_map;
  assign free_eff = |free_new;
  assign free_dbl = bus.free_valid_i && !free_eff;

  always_comb begin
    free_map_next = free_map;
    free_cnt_next = free_cnt;
    dbl_err_next  = dbl_err;
    if (bus.flush_i) begin
      free_map_next = '1;
      free_cnt_next = DEPTH_CNT;
    end else begin
      free_map_next = (free_map | free_new) & ~alloc_onehot;
      dbl_err_next  = dbl_err | free_dbl;
      if (free_eff && !alloc_fire) begin
        free_cnt_next = free_cnt + CNT_ONE;
      end else if (!free_eff && alloc_fire) begin
        free_cnt_next = free_cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_map <= '1;
      free_cnt <= DEPTH_CNT;
      dbl_err  <= 1'b0;
    end else begin
      free_map <= free_map_next;
      free_cnt <= free_cnt_next;
      dbl_err  <= dbl_err_next;
    end
  end

  assign bus.alloc_valid_o = any_free;
  assign bus.alloc_idx_o   = low_idx;
  assign bus.free_count_o  = free_cnt;
  assign bus.empty_o       = (free_cnt == '0);
  assign bus.double_free_o = dbl_err;

endmodule

// File: tb/tb_free_slot_alloc.sv
// Scoreboard bench for free_slot_alloc: reference bitmap model plus a queue of expected grants.
module tb_free_slot_alloc;
  import free_slot_alloc_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   tests = 0;
  int   failed = 0;

  logic [31:0] mMap;
  bit          mErr;
  int          expQ[$];

  free_slot_alloc_if #(.WIDTH(5)) bus ();

  free_slot_alloc #(.WIDTH(5), .DEPTH(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int lowestFree(input logic [31:0] m);
    for (int i = 0; i < 32; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic checkState();
    checkOutput("alloc_valid", int'(bus.alloc_valid_o), int'(mMap != 0));
    checkOutput("alloc_idx", int'(bus.alloc_idx_o), lowestFree(mMap));
    checkOutput("count_popcount", int'(bus.free_count_o), $countones(mMap));
    checkOutput("empty", int'(bus.empty_o), int'(mMap == 0));
    checkOutput("double_free", int'(bus.double_free_o), int'(mErr));
  endtask

  task automatic modelStep(input bit req, input bit fv, input int fidx, input bit fl);
    int  low;
    bit  fire;
    low  = lowestFree(mMap);
    fire = req && (mMap != 0);
    if (fl) begin
      mMap = '1;
    end else begin
      if (fv) begin
        if (fidx >= 32 || mMap[fidx]) mErr = 1'b1;
        else mMap[fidx] = 1'b1;
      end
      if (fire) mMap[low] = 1'b0;
    end
  endtask

  // One clock of stimulus: drive at negedge, check pre-edge state, score the grant, step the model.
  task automatic applyStimulus(input bit req, input bit fv, input int fidx, input bit fl);
    @(negedge clk_i);
    bus.alloc_req_i  = req;
    bus.free_valid_i = fv;
    bus.free_idx_i   = slot_idx_t'(fidx);
    bus.flush_i      = fl;
    #1;
    checkState();
    if (req && !fl && mMap != 0) expQ.push_back(lowestFree(mMap));
    if (bus.alloc_req_i && bus.alloc_valid_o && !bus.flush_i) begin
      if (expQ.size() == 0) checkOutput("grant_unexpected", int'(bus.alloc_idx_o), -1);
      else checkOutput("grant", int'(bus.alloc_idx_o), expQ.pop_front());
    end
    modelStep(req, fv, fidx, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic doReset();
    rst_ni           = 1'b0;
    bus.alloc_req_i  = 1'b0;
    bus.free_valid_i = 1'b0;
    bus.free_idx_i   = '0;
    bus.flush_i      = 1'b0;
    mMap = '1;
    mErr = 1'b0;
    expQ.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    doReset();
    idle(1);
    checkOutput("reset_valid", int'(bus.alloc_valid_o), 1);
    checkOutput("reset_idx", int'(bus.alloc_idx_o), 0);
    checkOutput("reset_count", int'(bus.free_count_o), 32);
    checkOutput("reset_empty", int'(bus.empty_o), 0);
    checkOutput("reset_dbl", int'(bus.double_free_o), 0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    idle(1);
    checkOutput("count_after4", int'(bus.free_count_o), 28);
    checkOutput("idx_after4", int'(bus.alloc_idx_o), 4);

    applyStimulus(1'b0, 1'b1, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    idle(1);
    checkOutput("count_refree", int'(bus.free_count_o), 28);
    checkOutput("idx_refree", int'(bus.alloc_idx_o), 4);

    doReset();
    for (int i = 0; i < 34; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    idle(1);
    checkOutput("full_valid", int'(bus.alloc_valid_o), 0);
    checkOutput("full_empty", int'(bus.empty_o), 1);
    checkOutput("full_count", int'(bus.free_count_o), 0);
    applyStimulus(1'b1, 1'b1, 7, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    idle(1);
    checkOutput("full_refill_count", int'(bus.free_count_o), 0);

    doReset();
    applyStimulus(1'b0, 1'b1, 5, 1'b0);
    idle(1);
    checkOutput("dbl_set", int'(bus.double_free_o), 1);
    checkOutput("dbl_count", int'(bus.free_count_o), 32);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    idle(2);
    checkOutput("dbl_sticky", int'(bus.double_free_o), 1);

    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2, 1'b0);
    idle(1);
    checkOutput("simul_count", int'(bus.free_count_o), 28);
    checkOutput("simul_idx", int'(bus.alloc_idx_o), 2);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    idle(1);
    checkOutput("flush_count", int'(bus.free_count_o), 32);
    checkOutput("flush_idx", int'(bus.alloc_idx_o), 0);

    doReset();
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    idle(1);
    checkOutput("self_free_dbl", int'(bus.double_free_o), 1);
    checkOutput("self_free_count", int'(bus.free_count_o), 31);
    checkOutput("self_free_idx", int'(bus.alloc_idx_o), 1);

    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                    int'($urandom_range(0, 31)), 1'($urandom_range(0, 99) < 3));
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_valid", int'(bus.alloc_valid_o), 1);
    checkOutput("async_idx", int'(bus.alloc_idx_o), 0);
    checkOutput("async_count", int'(bus.free_count_o), 32);
    checkOutput("async_empty", int'(bus.empty_o), 0);
    checkOutput("async_dbl", int'(bus.double_free_o), 0);
    doReset();
    idle(2);

    checkOutput("grant_queue_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
